// File: rtl/demux_1xn_stream_pkg.sv
// Shared definitions for the 1-to-NUM_OUT stream demultiplexer.
//   state_t : packet-routing FSM states
//     ST_IDLE - next accepted beat is the first beat of a packet
//     ST_PKT  - mid-packet, routed to the latched lane
//     ST_DROP - mid-packet with an unroutable select, beats are discarded
package demux_1xn_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/demux_1xn_stream_reg_slice.sv
// One-entry valid/ready register slice.
// A new entry may be loaded in the same cycle the held one drains, so a
// continuous stream moves at one beat per cycle with no bubble. The held
// payload only changes on a load, so it stays stable while stalled.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_data [W]         upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W]        held payload
module demux_1xn_stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld_p0;
  logic [W-1:0] data_p0;

  assign in_ready  = !vld_p0 || out_ready;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;

  // Stage p0: single buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (in_valid && in_ready) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_data;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-NUM_OUT stream demultiplexer.
// Each packet is routed whole to one output lane chosen by s_sel on its first
// beat; the lane stays locked until the beat carrying s_last. Packets whose
// select is out of range are swallowed and each discarded beat bumps a
// saturating counter. Outputs come from a one-entry register slice
// (latency 1, one beat per cycle sustained).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   s_valid/s_ready          input handshake
//   s_data [DATA_W]          input beat data
//   s_sel [SEL_W]            destination lane, sampled on first beat only
//   s_last                   final beat of packet
//   m_valid [NUM_OUT]        one-hot (or zero) lane valid
//   m_ready [NUM_OUT]        per-lane ready
//   m_data [DATA_W], m_last  shared output bus
//   busy                     packet in flight (PKT or DROP)
//   drop_cnt [CNT_W]         saturating count of discarded beats
module demux_1xn_stream
  import demux_1xn_stream_pkg::*;
#(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  localparam int SEL_W  = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [SEL_W-1:0]   s_sel,
  input  logic               s_last,
  output logic [NUM_OUT-1:0] m_valid,
  input  logic [NUM_OUT-1:0] m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int PAY_W = SEL_W + 1 + DATA_W;
  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   route_q, route_d;
  logic [CNT_W-1:0]   drop_cnt_q;

  logic               first_beat;
  logic               sel_oob;
  logic               drop_beat;
  logic [SEL_W-1:0]   dest;
  logic               accept;
  logic               slice_ready;
  logic               buf_v;
  logic [SEL_W-1:0]   dest_q;
  logic [PAY_W-1:0]   pay_in, pay_out;

  assign first_beat = (state_q == ST_IDLE);
  // Extra top bit so the comparison works when NUM_OUT is a power of two.
  assign sel_oob    = ({1'b0, s_sel} >= NUM_OUT_W);
  assign drop_beat  = (state_q == ST_DROP) || (first_beat && sel_oob);
  assign dest       = first_beat ? s_sel : route_q;

  // Drop-bound beats never touch the buffer, so they are always accepted.
  assign s_ready = rst_n && (drop_beat || slice_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!sel_oob) route_d = s_sel;
          if (!s_last)  state_d = sel_oob ? ST_DROP : ST_PKT;
        end
      end
      ST_PKT, ST_DROP: begin
        if (accept && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      route_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      if (accept && drop_beat) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign pay_in = {dest, s_last, s_data};

  demux_1xn_stream_reg_slice #(
    .W (PAY_W)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid && !drop_beat),
    .in_ready  (slice_ready),
    .in_data   (pay_in),
    .out_valid (buf_v),
    .out_ready (m_ready[dest_q]),
    .out_data  (pay_out)
  );

  assign dest_q   = pay_out[PAY_W-1 -: SEL_W];
  assign m_last   = pay_out[DATA_W];
  assign m_data   = pay_out[DATA_W-1:0];
  assign m_valid  = NUM_OUT'(buf_v) << dest_q;
  assign busy     = (state_q != ST_IDLE);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed bench for demux_1xn_stream: a 2-lane instance (d2) and a 3-lane
// instance with a 2-bit drop counter (d3).
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 2-lane instance
  logic       d2_s_valid, d2_s_ready, d2_s_sel, d2_s_last;
  logic [7:0] d2_s_data, d2_m_data;
  logic [1:0] d2_m_valid, d2_m_ready;
  logic       d2_m_last, d2_busy;
  logic [7:0] d2_drop_cnt;

  // 3-lane instance
  logic       d3_s_valid, d3_s_ready, d3_s_last;
  logic [1:0] d3_s_sel;
  logic [7:0] d3_s_data, d3_m_data;
  logic [2:0] d3_m_valid, d3_m_ready;
  logic       d3_m_last, d3_busy;
  logic [1:0] d3_drop_cnt;

  demux_1xn_stream #(.NUM_OUT(2), .DATA_W(8), .CNT_W(8)) d2 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(d2_s_valid), .s_ready(d2_s_ready), .s_data(d2_s_data),
    .s_sel(d2_s_sel), .s_last(d2_s_last),
    .m_valid(d2_m_valid), .m_ready(d2_m_ready), .m_data(d2_m_data),
    .m_last(d2_m_last), .busy(d2_busy), .drop_cnt(d2_drop_cnt)
  );

  demux_1xn_stream #(.NUM_OUT(3), .DATA_W(8), .CNT_W(2)) d3 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(d3_s_valid), .s_ready(d3_s_ready), .s_data(d3_s_data),
    .s_sel(d3_s_sel), .s_last(d3_s_last),
    .m_valid(d3_m_valid), .m_ready(d3_m_ready), .m_data(d3_m_data),
    .m_last(d3_m_last), .busy(d3_busy), .drop_cnt(d3_drop_cnt)
  );

  task automatic drive2(input logic v, input logic sel, input logic [7:0] d, input logic l);
    d2_s_valid = v; d2_s_sel = sel; d2_s_data = d; d2_s_last = l;
  endtask

  task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
    d3_s_valid = v; d3_s_sel = sel; d3_s_data = d; d3_s_last = l;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_init;
    #1;
    vectors++;
    if (d2_m_valid !== 2'b00 || d2_busy !== 1'b0 || d2_drop_cnt !== 8'd0 || d2_s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL init_d2: m_valid=%b busy=%b drop_cnt=%0d s_ready=%b, want 00 0 0 0",
               d2_m_valid, d2_busy, d2_drop_cnt, d2_s_ready);
    end
    vectors++;
    if (d3_m_valid !== 3'b000 || d3_drop_cnt !== 2'd0 || d3_m_data !== 8'h00 || d3_m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL init_d3: m_valid=%b drop_cnt=%0d m_data=%h m_last=%b, want 000 0 00 0",
               d3_m_valid, d3_drop_cnt, d3_m_data, d3_m_last);
    end
  endtask

  task automatic test_single;
    d2_m_ready = 2'b11;
    drive2(1'b1, 1'b1, 8'hA5, 1'b1);
    #1;
    vectors++;
    if (d2_s_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_s_ready: got %b want 1", d2_s_ready);
    end
    tick();
    drive2(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (d2_m_valid !== 2'b10 || d2_m_data !== 8'hA5 || d2_m_last !== 1'b1) begin
      miscompares++;
      $display("FAIL single_out: m_valid=%b m_data=%h m_last=%b want 10 a5 1",
               d2_m_valid, d2_m_data, d2_m_last);
    end
    tick();
    vectors++;
    if (d2_m_valid !== 2'b00) begin
      miscompares++; $display("FAIL single_clear: m_valid=%b want 00", d2_m_valid);
    end
  endtask

  task automatic test_packet_lock;
    logic [7:0] exp_d [3] = '{8'h01, 8'h02, 8'h03};
    logic       sel_v [3] = '{1'b0, 1'b1, 1'b1};
    d2_m_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      drive2(1'b1, sel_v[i], exp_d[i], (i == 2));
      tick();
      vectors++;
      if (d2_m_valid !== 2'b01 || d2_m_data !== exp_d[i] || d2_m_last !== (i == 2) ||
          d2_busy !== (i != 2)) begin
        miscompares++;
        $display("FAIL lock_beat%0d: m_valid=%b m_data=%h m_last=%b busy=%b want 01 %h %b %b",
                 i, d2_m_valid, d2_m_data, d2_m_last, d2_busy, exp_d[i], (i == 2), (i != 2));
      end
    end
    drive2(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    vectors++;
    if (d2_m_valid !== 2'b00) begin
      miscompares++; $display("FAIL lock_clear: m_valid=%b want 00", d2_m_valid);
    end
  endtask

  task automatic test_backpressure;
    d2_m_ready = 2'b10;
    drive2(1'b1, 1'b0, 8'h10, 1'b0);
    tick();
    drive2(1'b1, 1'b0, 8'h11, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (d2_s_ready !== 1'b0 || d2_m_valid !== 2'b01 || d2_m_data !== 8'h10) begin
        miscompares++;
        $display("FAIL stall%0d: s_ready=%b m_valid=%b m_data=%h want 0 01 10",
                 k, d2_s_ready, d2_m_valid, d2_m_data);
      end
      tick();
    end
    d2_m_ready = 2'b11;
    tick();
    for (int idx = 2; idx <= 5; idx++) begin
      vectors++;
      if (d2_m_valid !== 2'b01 || d2_m_data !== 8'(8'h10 + idx - 1)) begin
        miscompares++;
        $display("FAIL drain%0d: m_valid=%b m_data=%h want 01 %h",
                 idx, d2_m_valid, d2_m_data, 8'(8'h10 + idx - 1));
      end
      drive2(1'b1, 1'b0, 8'(8'h10 + idx), (idx == 5));
      tick();
    end
    drive2(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (d2_m_valid !== 2'b01 || d2_m_data !== 8'h15 || d2_m_last !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_last: m_valid=%b m_data=%h m_last=%b want 01 15 1",
               d2_m_valid, d2_m_data, d2_m_last);
    end
    tick();
    vectors++;
    if (d2_m_valid !== 2'b00) begin
      miscompares++; $display("FAIL bp_clear: m_valid=%b want 00", d2_m_valid);
    end
  endtask

  task automatic test_drop;
    logic [1:0] exp_cnt;
    d3_m_ready = 3'b111;
    for (int i = 0; i < 5; i++) begin
      drive3(1'b1, 2'd3, 8'(8'hD0 + i), (i == 4));
      #1;
      vectors++;
      if (d3_s_ready !== 1'b1) begin
        miscompares++; $display("FAIL drop_ready%0d: s_ready=%b want 1", i, d3_s_ready);
      end
      tick();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      vectors++;
      if (d3_m_valid !== 3'b000 || d3_drop_cnt !== exp_cnt || d3_busy !== (i != 4)) begin
        miscompares++;
        $display("FAIL drop_beat%0d: m_valid=%b drop_cnt=%0d busy=%b want 000 %0d %b",
                 i, d3_m_valid, d3_drop_cnt, d3_busy, exp_cnt, (i != 4));
      end
    end
    drive3(1'b1, 2'd2, 8'h5A, 1'b1);
    tick();
    drive3(1'b0, 2'd0, 8'h00, 1'b0);
    vectors++;
    if (d3_m_valid !== 3'b100 || d3_m_data !== 8'h5A || d3_drop_cnt !== 2'd3) begin
      miscompares++;
      $display("FAIL drop_after: m_valid=%b m_data=%h drop_cnt=%0d want 100 5a 3",
               d3_m_valid, d3_m_data, d3_drop_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    d3_m_ready = 3'b111;
    drive3(1'b1, 2'd0, 8'h61, 1'b1);
    tick();
    drive3(1'b1, 2'd1, 8'h62, 1'b1);
    vectors++;
    if (d3_m_valid !== 3'b001 || d3_m_data !== 8'h61) begin
      miscompares++;
      $display("FAIL b2b_first: m_valid=%b m_data=%h want 001 61", d3_m_valid, d3_m_data);
    end
    tick();
    drive3(1'b0, 2'd0, 8'h00, 1'b0);
    vectors++;
    if (d3_m_valid !== 3'b010 || d3_m_data !== 8'h62) begin
      miscompares++;
      $display("FAIL b2b_second: m_valid=%b m_data=%h want 010 62", d3_m_valid, d3_m_data);
    end
    tick();
    vectors++;
    if (d3_m_valid !== 3'b000) begin
      miscompares++; $display("FAIL b2b_clear: m_valid=%b want 000", d3_m_valid);
    end
  endtask

  task automatic test_reset;
    d2_m_ready = 2'b11;
    drive2(1'b1, 1'b0, 8'h31, 1'b0);
    tick();
    drive2(1'b0, 1'b0, 8'h00, 1'b0);
    d2_m_ready = 2'b00;
    vectors++;
    if (d2_m_valid !== 2'b01 || d2_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_setup: m_valid=%b busy=%b want 01 1", d2_m_valid, d2_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (d2_m_valid !== 2'b00 || d2_busy !== 1'b0 || d2_s_ready !== 1'b0 ||
        d2_m_data !== 8'h00 || d3_drop_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_async: m_valid=%b busy=%b s_ready=%b m_data=%h d3_drop_cnt=%0d want 00 0 0 00 0",
               d2_m_valid, d2_busy, d2_s_ready, d2_m_data, d3_drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    d2_m_ready = 2'b11;
    drive2(1'b1, 1'b1, 8'h32, 1'b1);
    tick();
    drive2(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (d2_m_valid !== 2'b10 || d2_m_data !== 8'h32 || d2_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after: m_valid=%b m_data=%h busy=%b want 10 32 0",
               d2_m_valid, d2_m_data, d2_busy);
    end
    tick();
  endtask

  initial begin
    drive2(1'b0, 1'b0, 8'h00, 1'b0);
    drive3(1'b0, 2'd0, 8'h00, 1'b0);
    d2_m_ready = 2'b00;
    d3_m_ready = 3'b000;
    rst_n = 1'b0;
    test_reset_init();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    test_single();
    test_packet_lock();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
